// File: rtl/mem_bus_bridge_pkg.sv
// Shared types for the CPU memory bus bridge: FSM states, region decode and
// the value returned for vacant reads.
package mem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRamRd,
    StPerWait,
    StErr
  } state_e;

  typedef enum logic [1:0] {
    RegionRam,
    RegionPer,
    RegionUnmapped
  } region_e;

  localparam logic [15:0] VacantRead = 16'h3FFF;

  // RAM wins over the peripheral window if the two ever overlap.
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input logic [15:0] ram_base,
                                            input logic [15:0] ram_size,
                                            input logic [15:0] per_limit);
    logic [16:0] ram_end;
    ram_end = {1'b0, ram_base} + {1'b0, ram_size};
    if (({1'b0, addr} >= {1'b0, ram_base}) && ({1'b0, addr} < ram_end)) begin
      return RegionRam;
    end else if (addr <= per_limit) begin
      return RegionPer;
    end else begin
      return RegionUnmapped;
    end
  endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// CPU-side, RAM-side and peripheral-side signals of the memory bus bridge.
// master = CPU/RAM/peripheral side, slave = the bridge itself.
interface mem_bus_bridge_if #(
  parameter int unsigned RamAw = 10
) ();

  logic             MREQ;
  logic [15:0]      MAB;
  logic [15:0]      MDBout;
  logic             BW;
  logic             MW;
  logic [15:0]      MDBin;
  logic             MRDY;
  logic             ram_en;
  logic             ram_we;
  logic [RamAw-1:0] ram_addr;
  logic [1:0]       ram_be;
  logic [15:0]      ram_wdata;
  logic [15:0]      ram_rdata;
  logic             per_en;
  logic             per_we;
  logic [15:0]      per_addr;
  logic [1:0]       per_be;
  logic [15:0]      per_wdata;
  logic [15:0]      per_rdata;
  logic             per_ack;
  logic             bus_err;

  modport slave (
    input  MREQ, MAB, MDBout, BW, MW, ram_rdata, per_rdata, per_ack,
    output MDBin, MRDY, ram_en, ram_we, ram_addr, ram_be, ram_wdata,
    output per_en, per_we, per_addr, per_be, per_wdata, bus_err
  );

  modport master (
    output MREQ, MAB, MDBout, BW, MW, ram_rdata, per_rdata, per_ack,
    input  MDBin, MRDY, ram_en, ram_we, ram_addr, ram_be, ram_wdata,
    input  per_en, per_we, per_addr, per_be, per_wdata, bus_err
  );

endinterface

// File: rtl/mem_lane_steer.sv
// Byte-lane steering: byte enables and write-data replication on the way out,
// lane selection and zero-extension of read data on the way back.
module mem_lane_steer (
  input  logic        bw_i,
  input  logic        a0_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] rdata_i,
  output logic [1:0]  be_o,
  output logic [15:0] wdata_o,
  output logic [15:0] rdata_o
);

  always_comb begin
    if (bw_i) begin
      be_o    = a0_i ? 2'b10 : 2'b01;
      wdata_o = {wdata_i[7:0], wdata_i[7:0]};
      rdata_o = {8'h00, (a0_i ? rdata_i[15:8] : rdata_i[7:0])};
    end else begin
      be_o    = 2'b11;
      wdata_o = wdata_i;
      rdata_o = rdata_i;
    end
  end

endmodule

// File: rtl/mem_bus_bridge.sv
// Decodes CPU bus cycles into zero/one-wait RAM accesses or handshaked
// peripheral accesses with an ack timeout; stalls the CPU through MRDY.
module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter logic [15:0] RAM_BASE  = 16'h1C00,
  parameter logic [15:0] RAM_SIZE  = 16'h0800,
  parameter logic [15:0] PER_LIMIT = 16'h0FFF,
  parameter int unsigned TIMEOUT   = 8
) (
  input logic           MCLK,
  input logic           reset,
  mem_bus_bridge_if.slave bus
);

  localparam int unsigned RamAw      = $clog2(RAM_SIZE) - 1;
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        per_en_q, per_en_d;
  logic        per_we_q, per_we_d;
  logic [15:0] per_addr_q, per_addr_d;
  logic [1:0]  per_be_q, per_be_d;
  logic [15:0] per_wdata_q, per_wdata_d;

  region_e     region;
  logic [15:0] ram_off;
  logic [1:0]  lane_be;
  logic [15:0] lane_wdata;
  logic [15:0] rdata_raw;
  logic [15:0] rdata_aligned;
  logic        unused_ram_off;

  assign region         = decode_region(bus.MAB, RAM_BASE, RAM_SIZE, PER_LIMIT);
  assign ram_off        = bus.MAB - RAM_BASE;
  assign unused_ram_off = ^{ram_off[15:RamAw+1], ram_off[0]};

  // The CPU holds MAB/BW stable while stalled, so one steering instance serves
  // both the request cycle and the completion cycle.
  assign rdata_raw = (state_q == StRamRd) ? bus.ram_rdata : bus.per_rdata;

  mem_lane_steer u_lane_steer (
    .bw_i    (bus.BW),
    .a0_i    (bus.MAB[0]),
    .wdata_i (bus.MDBout),
    .rdata_i (rdata_raw),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (rdata_aligned)
  );

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      per_en_q    <= 1'b0;
      per_we_q    <= 1'b0;
      per_addr_q  <= '0;
      per_be_q    <= '0;
      per_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      per_en_q    <= per_en_d;
      per_we_q    <= per_we_d;
      per_addr_q  <= per_addr_d;
      per_be_q    <= per_be_d;
      per_wdata_q <= per_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    per_en_d    = per_en_q;
    per_we_d    = per_we_q;
    per_addr_d  = per_addr_q;
    per_be_d    = per_be_q;
    per_wdata_d = per_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.MREQ) begin
          if (region == RegionRam && !bus.MW) begin
            state_d = StRamRd;
          end else if (region == RegionPer) begin
            state_d     = StPerWait;
            cnt_d       = '0;
            per_en_d    = 1'b1;
            per_we_d    = bus.MW;
            per_addr_d  = bus.MAB;
            per_be_d    = lane_be;
            per_wdata_d = bus.MW ? lane_wdata : 16'h0000;
          end
        end
      end
      StRamRd: state_d = StIdle;
      StPerWait: begin
        cnt_d = cnt_q + 8'd1;
        // Ack is tested first so an ack on the final wait cycle still completes.
        if (bus.per_ack) begin
          state_d  = StIdle;
          per_en_d = 1'b0;
          per_we_d = 1'b0;
        end else if (cnt_d == TimeoutCnt) begin
          state_d  = StErr;
          per_en_d = 1'b0;
          per_we_d = 1'b0;
        end
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.MRDY      = 1'b1;
    bus.MDBin     = 16'h0000;
    bus.bus_err   = 1'b0;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_be    = 2'b00;
    bus.ram_wdata = 16'h0000;
    unique case (state_q)
      StIdle: begin
        if (bus.MREQ) begin
          unique case (region)
            RegionRam: begin
              bus.ram_en    = 1'b1;
              bus.ram_we    = bus.MW;
              bus.ram_addr  = ram_off[RamAw:1];
              bus.ram_be    = lane_be;
              bus.ram_wdata = bus.MW ? lane_wdata : 16'h0000;
              bus.MRDY      = bus.MW;
            end
            RegionPer: bus.MRDY = 1'b0;
            default: begin
              bus.bus_err = 1'b1;
              if (!bus.MW) bus.MDBin = VacantRead;
            end
          endcase
        end
      end
      StRamRd: bus.MDBin = rdata_aligned;
      StPerWait: begin
        if (bus.per_ack) begin
          if (!bus.MW) bus.MDBin = rdata_aligned;
        end else begin
          bus.MRDY = 1'b0;
        end
      end
      StErr: begin
        bus.bus_err = 1'b1;
        if (!bus.MW) bus.MDBin = VacantRead;
      end
      default: ;
    endcase
  end

  assign bus.per_en    = per_en_q;
  assign bus.per_we    = per_we_q;
  assign bus.per_addr  = per_addr_q;
  assign bus.per_be    = per_be_q;
  assign bus.per_wdata = per_wdata_q;

endmodule
